commit_progress_monitor: RTL and testbench
==========================================

# commit_progress_monitor

Synthesizable, parametrised commit-progress monitor for simulation and FPGA-emulation tops. It counts committed instructions across `COMMIT_WIDTH` ROB commit lanes, ignoring walk cycles, and counts cycles. It detects a core hang (no commit for `STUCK_LIMIT` cycles) and emits snapshot reports for periodic, UART-query and hang events through a valid/ready port. It sits beside the core in the sim top, and a testbench-side or debug-module consumer drains the report port.

## Interface
Parameters:
- `COMMIT_WIDTH`, 6: number of commit lanes.
- `CNT_WIDTH`, 64: width of instruction and cycle counters; both wrap modulo 2^CNT_WIDTH.
- `STUCK_LIMIT`, 5000: commit-free cycles tolerated; exceeding it declares a hang. Must be ≥ 1.
- `REPORT_INTERVAL`, 10000: cycles between periodic reports. Must be ≥ 1.

Ports:
- `clock`  in  1  sole clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `commit_valid`  in  COMMIT_WIDTH  per-lane commit valid.
- `commit_is_walk`  in  1  when high, commit lanes carry walk, not commit.
- `uart_query`  in  1  single-cycle UART-input request from the MMIO block.
- `instr_count`  out  CNT_WIDTH  committed instructions since reset.
- `cycle_count`  out  CNT_WIDTH  cycles since reset release.
- `stuck`  out  1  sticky hang flag.
- `report_valid`  out  1  report holding register is full.
- `report_ready`  in  1  consumer accepts the report.
- `report_kind`  out  3  {stuck, uart, periodic} cause bits; more than one may be set.
- `report_cycle`, `report_instr`  out  CNT_WIDTH each  snapshot values.
- `report_drops`  out  16  events lost while the holding register was full; saturates at 0xFFFF.

## Operation
- Commit qualifier: `commit = !commit_is_walk`. Increment is popcount(`commit_valid`) when commit, else 0. The adder is $clog2(COMMIT_WIDTH+1) bits, zero-extended to CNT_WIDTH. Any lane set counts, including non-contiguous lanes.
- `cycle_count` increments by 1 every cycle after reset.
- Stuck timer is internal, $clog2(STUCK_LIMIT+2) bits:
  - cleared on any cycle with commit and a nonzero increment;
  - otherwise increments, saturating at STUCK_LIMIT+1.
- FSM with 2 states, RUN and HALTED. Reset state is RUN.
  - RUN → HALTED when the timer reads STUCK_LIMIT and this cycle has no commit, i.e. STUCK_LIMIT+1 consecutive commit-free cycles.
  - HALTED exits only on reset. In HALTED, `stuck`=1 and the counters keep running.
  - The transition raises one stuck event.
- Periodic event: an internal down-counter is loaded with REPORT_INTERVAL−1 at reset and decrements each cycle.
  - At 0 it raises a periodic event and reloads.
  - Events therefore fire when `cycle_count` = k·REPORT_INTERVAL−1, k ≥ 1. No event fires at cycle 0.
- UART event: `uart_query`=1 in a cycle.
- Event capture, on any event cycle:
  - If the holding register is empty, or is being drained this cycle (`report_valid && report_ready`): load `report_kind` with the OR of all same-cycle causes, and load `report_cycle`/`report_instr` with the pre-update `cycle_count`/`instr_count` of that cycle.
  - Otherwise: the event is dropped and `report_drops` increments by 1 per dropped cycle, saturating.
- Handshake: a report is transferred on `report_valid && report_ready`. The payload stays stable while valid && !ready.

## Timing
- All outputs reset to 0 asynchronously: counters, `stuck`, `report_*`, `report_drops`. The FSM resets to RUN.
- Reset deassertion is assumed synchronised externally.
- Counter outputs are registered and reflect inputs with 1-cycle latency.
- An event in cycle t gives `report_valid`=1 in cycle t+1.
- Drain and refill in the same cycle gives back-to-back reports with no bubble.
- Reset mid-report discards the pending report; no drop is counted.
- Commit and walk in the same cycle: walk wins, no count, and the stuck timer is not cleared.

## Test plan
- Reset release, 6 lanes all valid for 10 cycles, walk=0 → `instr_count`=60 and `cycle_count`=10 at cycle 10; `stuck`=0.
- Same lanes with `commit_is_walk`=1 for 5001 cycles after the last commit → `stuck` rises exactly 5001 cycles after the last commit. A report with kind=3'b100 follows and `instr_count` stays unchanged.
- REPORT_INTERVAL=4, `report_ready`=1 → reports with `report_cycle`=3, 7, 11, kind=3'b001.
- `uart_query` coincident with the periodic event at cycle 3 → a single report with kind=3'b011; `report_drops`=0.
- `report_ready`=0, REPORT_INTERVAL=4, run 20 cycles → the first report is held with `report_cycle`=3 and `report_drops`=4. Then assert ready → transfer in 1 cycle, and the next event refills the register.
- Assert `reset_n`=0 mid-run while HALTED with a report pending → all outputs read 0 immediately (asynchronously); after release, the FSM is in RUN.

Source files
------------

// File: rtl/commit_progress_monitor.sv
// commit_progress_monitor
//   Counts committed instructions over COMMIT_WIDTH ROB commit lanes and
//   counts cycles. Walk cycles do not count. Declares a sticky hang after
//   STUCK_LIMIT+1 consecutive commit-free cycles. Emits snapshot reports for
//   periodic, UART-query and hang events through a one-entry valid/ready
//   holding register.
//
// Ports
//   clock, reset_n        clock, asynchronous active-low reset
//   commit_valid[CW]      per-lane commit valid
//   commit_is_walk        lanes carry walk, not commit
//   uart_query            single-cycle UART input request
//   instr_count, cycle_count   running counters (wrap)
//   stuck                 sticky hang flag
//   report_valid/ready    report handshake
//   report_kind           {stuck, uart, periodic}
//   report_cycle/instr    snapshot of the counters in the event cycle
//   report_drops          saturating count of dropped event cycles
module commit_progress_monitor #(
    parameter int unsigned COMMIT_WIDTH    = 6,
    parameter int unsigned CNT_WIDTH       = 64,
    parameter int unsigned STUCK_LIMIT     = 5000,
    parameter int unsigned REPORT_INTERVAL = 10000
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [COMMIT_WIDTH-1:0] commit_valid,
    input  logic                    commit_is_walk,
    input  logic                    uart_query,
    output logic [CNT_WIDTH-1:0]    instr_count,
    output logic [CNT_WIDTH-1:0]    cycle_count,
    output logic                    stuck,
    output logic                    report_valid,
    input  logic                    report_ready,
    output logic [2:0]              report_kind,
    output logic [CNT_WIDTH-1:0]    report_cycle,
    output logic [CNT_WIDTH-1:0]    report_instr,
    output logic [15:0]             report_drops
);

    localparam int unsigned INC_W = $clog2(COMMIT_WIDTH + 1);
    localparam int unsigned TMR_W = $clog2(STUCK_LIMIT + 2);
    localparam int unsigned PER_W = (REPORT_INTERVAL > 1) ? $clog2(REPORT_INTERVAL) : 1;

    localparam logic [TMR_W-1:0] TMR_LIMIT  = TMR_W'(STUCK_LIMIT);
    localparam logic [TMR_W-1:0] TMR_SAT    = TMR_W'(STUCK_LIMIT + 1);
    localparam logic [PER_W-1:0] PER_RELOAD = PER_W'(REPORT_INTERVAL - 1);

    typedef enum logic {RUN, HALTED} state_t;

    state_t           state;
    logic [TMR_W-1:0] stuck_timer;
    logic [PER_W-1:0] per_cnt;

    logic [INC_W-1:0] inc;
    logic             commit_nz;
    logic             stuck_ev;
    logic             per_ev;
    logic [2:0]       ev_kind;
    logic             accept;

    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < COMMIT_WIDTH; i++) begin
            inc = inc + INC_W'(commit_valid[i]);
        end
        // Walk wins over commit: nothing counts and the timer is not cleared.
        if (commit_is_walk) begin
            inc = '0;
        end
        commit_nz = !commit_is_walk && (|commit_valid);
        stuck_ev  = (state == RUN) && (stuck_timer == TMR_LIMIT) && !commit_nz;
        per_ev    = (per_cnt == '0);
        ev_kind   = {stuck_ev, uart_query, per_ev};
        // A register being drained this cycle can take a new event directly.
        accept    = !report_valid || report_ready;
    end

    // Hang FSM; HALTED is left only through reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
            stuck <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (stuck_ev) begin
                        state <= HALTED;
                        stuck <= 1'b1;
                    end
                end
                HALTED: begin
                    stuck <= 1'b1;
                end
                default: begin
                    state <= RUN;
                    stuck <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            instr_count  <= '0;
            cycle_count  <= '0;
            stuck_timer  <= '0;
            per_cnt      <= PER_RELOAD;
            report_valid <= 1'b0;
            report_kind  <= '0;
            report_cycle <= '0;
            report_instr <= '0;
            report_drops <= '0;
        end else begin
            instr_count <= instr_count + CNT_WIDTH'(inc);
            cycle_count <= cycle_count + 1'b1;

            if (commit_nz) begin
                stuck_timer <= '0;
            end else if (stuck_timer != TMR_SAT) begin
                stuck_timer <= stuck_timer + 1'b1;
            end

            if (per_ev) begin
                per_cnt <= PER_RELOAD;
            end else begin
                per_cnt <= per_cnt - 1'b1;
            end

            if (ev_kind != 3'b000) begin
                if (accept) begin
                    report_valid <= 1'b1;
                    report_kind  <= ev_kind;
                    report_cycle <= cycle_count;
                    report_instr <= instr_count;
                end else if (report_drops != 16'hFFFF) begin
                    report_drops <= report_drops + 1'b1;
                end
            end else if (report_valid && report_ready) begin
                report_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_commit_progress_monitor.sv
// Randomized scoreboard bench for commit_progress_monitor.
module tb_commit_progress_monitor;

    localparam int unsigned CW = 6;
    localparam int unsigned NW = 64;
    localparam int unsigned SL = 30;
    localparam int unsigned RI = 4;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [CW-1:0] commit_valid;
    logic          commit_is_walk;
    logic          uart_query;
    logic [NW-1:0] instr_count;
    logic [NW-1:0] cycle_count;
    logic          stuck;
    logic          report_valid;
    logic          report_ready;
    logic [2:0]    report_kind;
    logic [NW-1:0] report_cycle;
    logic [NW-1:0] report_instr;
    logic [15:0]   report_drops;

    commit_progress_monitor #(
        .COMMIT_WIDTH(CW),
        .CNT_WIDTH(NW),
        .STUCK_LIMIT(SL),
        .REPORT_INTERVAL(RI)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .commit_valid(commit_valid),
        .commit_is_walk(commit_is_walk),
        .uart_query(uart_query),
        .instr_count(instr_count),
        .cycle_count(cycle_count),
        .stuck(stuck),
        .report_valid(report_valid),
        .report_ready(report_ready),
        .report_kind(report_kind),
        .report_cycle(report_cycle),
        .report_instr(report_instr),
        .report_drops(report_drops)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [2:0]    kind;
        logic [NW-1:0] cyc;
        logic [NW-1:0] ins;
    } rep_t;

    rep_t sb[$];

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the spec says the outputs are after each cycle.
    logic [NW-1:0] m_instr, m_cyc;
    int            m_run;
    bit            m_halt, m_full;
    int            m_drops;

    // Stimulus modes
    bit  all_lanes;
    int  walk_pct, uart_pct, ready_pct;
    longint uart_at;

    task automatic chk(input string name, input logic [NW-1:0] act, input logic [NW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_instr = '0;
        m_cyc   = '0;
        m_run   = 0;
        m_halt  = 0;
        m_full  = 0;
        m_drops = 0;
        sb.delete();
    endtask

    // One cycle of the reference, using the inputs that were applied to it.
    task automatic model_step();
        bit       free, sev, pev, drained;
        int       inc;
        logic [2:0] kind;
        rep_t     r;
        free = commit_is_walk || (commit_valid == '0);
        inc  = commit_is_walk ? 0 : $countones(commit_valid);
        if (free) begin
            if (m_run < 1000000) m_run++;
        end else begin
            m_run = 0;
        end
        sev = !m_halt && free && (m_run == SL + 1);
        if (sev) m_halt = 1;
        pev = ((m_cyc + 1) % RI) == 0;
        kind = {sev, uart_query, pev};
        drained = m_full && report_ready;
        if (kind != 3'b000) begin
            if (!m_full || drained) begin
                r.kind = kind;
                r.cyc  = m_cyc;
                r.ins  = m_instr;
                sb.push_back(r);
                m_full = 1;
            end else if (m_drops != 16'hFFFF) begin
                m_drops++;
            end
        end else if (drained) begin
            m_full = 0;
        end
        m_instr = m_instr + NW'(inc);
        m_cyc   = m_cyc + 1;
    endtask

    task automatic pick_inputs();
        commit_valid   = all_lanes ? '1 : CW'($urandom);
        commit_is_walk = ($urandom_range(99) < walk_pct);
        uart_query     = ($urandom_range(99) < uart_pct) || (longint'(m_cyc) == uart_at);
        report_ready   = ($urandom_range(99) < ready_pct);
    endtask

    task automatic cycle_step();
        @(posedge clock);
        #1;
        model_step();
        pick_inputs();
    endtask

    task automatic set_mode(input bit a, input int w, input int u, input int r);
        all_lanes = a;
        walk_pct  = w;
        uart_pct  = u;
        ready_pct = r;
    endtask

    // Monitor: compares counters every cycle and pops a report on each transfer.
    initial begin
        rep_t e;
        forever begin
            @(negedge clock);
            if (reset_n) begin
                chk("instr_count", instr_count, m_instr);
                chk("cycle_count", cycle_count, m_cyc);
                chk("stuck", NW'(stuck), NW'(m_halt));
                chk("report_valid", NW'(report_valid), NW'(m_full));
                chk("report_drops", NW'(report_drops), NW'(m_drops));
                if (report_valid && report_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL report_unexpected: got kind=%0b cyc=%0h with empty scoreboard", report_kind, report_cycle);
                    end else begin
                        e = sb.pop_front();
                        chk("report_kind", NW'(report_kind), NW'(e.kind));
                        chk("report_cycle", report_cycle, e.cyc);
                        chk("report_instr", report_instr, e.ins);
                    end
                end
            end
        end
    end

    initial begin
        int waited;
        reset_n        = 1'b0;
        commit_valid   = '0;
        commit_is_walk = 1'b0;
        uart_query     = 1'b0;
        report_ready   = 1'b0;
        uart_at        = -1;
        model_reset();
        #1;
        chk("reset_instr", instr_count, '0);
        chk("reset_valid", NW'(report_valid), '0);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;

        // All six lanes for 10 cycles, UART coincident with the cycle-3 periodic event.
        set_mode(1, 0, 0, 100);
        uart_at = 3;
        pick_inputs();
        repeat (10) cycle_step();
        uart_at = -1;
        chk("instr_at_10", instr_count, 64'd60);
        chk("cycle_at_10", cycle_count, 64'd10);
        chk("stuck_at_10", NW'(stuck), '0);

        // Random mix with backpressure.
        set_mode(0, 20, 10, 60);
        repeat (300) cycle_step();

        // Consumer stalled: drops accumulate while the first report is held.
        set_mode(0, 20, 5, 0);
        repeat (20) cycle_step();
        set_mode(0, 20, 5, 100);
        repeat (20) cycle_step();

        // Walk-only cycles until hang, bounded.
        set_mode(1, 100, 0, 100);
        waited = 0;
        while (!stuck && waited < SL + 10) begin
            cycle_step();
            waited++;
        end
        repeat (4) cycle_step();
        chk("stuck_raised", NW'(stuck), 64'd1);

        // Halted with a pending report, then asynchronous reset mid-cycle.
        set_mode(0, 30, 100, 0);
        repeat (3) cycle_step();
        #1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst_instr", instr_count, '0);
        chk("arst_cycle", cycle_count, '0);
        chk("arst_stuck", NW'(stuck), '0);
        chk("arst_valid", NW'(report_valid), '0);
        chk("arst_kind", NW'(report_kind), '0);
        chk("arst_rcycle", report_cycle, '0);
        chk("arst_rinstr", report_instr, '0);
        chk("arst_drops", NW'(report_drops), '0);
        repeat (2) @(posedge clock);
        #1;
        reset_n = 1'b1;
        set_mode(0, 10, 10, 70);
        pick_inputs();
        repeat (200) cycle_step();
        chk("run_after_reset", NW'(stuck), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
